dz_rx_silo: RTL and testbench

- Parametrised receive-silo front end for the DZ-style multiplexer: scans NLINES UART receivers, stores characters in a DEPTH-entry silo, and presents the head entry as the RBUF word.
- Improvements over the fixed 8-line design:
  - Round-robin arbiter services one full line per clock, replacing the fixed one-line-per-clock scan.
  - Per-line receiver enable.
  - Parametrised alarm threshold.
  - Silo fill-level output for diagnostics.
- Sits between the per-line UART receivers and the CSR/register file.

---
 rtl/dz_pkg.sv | 42 ++++
 rtl/dz_fifo.sv | 73 +++++++
 rtl/dz_rr_arb.sv | 55 +++++
 rtl/dz_rx_silo.sv | 152 +++++++++++++++
 tb/tb_dz_rx_silo.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dz_pkg.sv
// rtl/dz_pkg.sv - shared types, sizing helper and RBUF field positions for the DZ receive silo
package dz_pkg;

  // Status nibble carried by every silo entry, ahead of the line number and character.
  // A full entry is {dz_flags_t, line[LW], data[DWIDTH]}, the low RW-1 bits of RBUF.
  typedef struct packed {
    logic ovre;   // an earlier character was lost to a full silo
    logic fe;     // framing error
    logic pe;     // parity error
    logic rsv;    // always zero; keeps the RBUF layout of the original block
  } dz_flags_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // RBUF flag bit positions for a word of width rw.
  function automatic int rb_dval(input int rw);
    return rw - 1;
  endfunction

  function automatic int rb_ovre(input int rw);
    return rw - 2;
  endfunction

  function automatic int rb_fe(input int rw);
    return rw - 3;
  endfunction

  function automatic int rb_pe(input int rw);
    return rw - 4;
  endfunction

endpackage

// File: rtl/dz_fifo.sv
// rtl/dz_fifo.sv - synchronous FIFO used as the receive silo storage
//   clk, rst   clock, asynchronous active-low reset
//   clr        synchronous flush
//   wr_en      push wr_data (ignored when full)
//   rd_en      pop the head (ignored when empty)
//   rd_data    head entry, combinational
//   level      number of stored entries
//   empty/full occupancy flags
module dz_fifo
  import dz_pkg::*;
#(
  parameter  int WIDTH = 15,
  parameter  int DEPTH = 64,
  localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rp];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) begin
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      end
      if (do_rd) begin
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dz_rr_arb.sv
// rtl/dz_rr_arb.sv - round-robin arbiter granting one requesting line per clock
//   clk, rst   clock, asynchronous active-low reset
//   clr        synchronous clear of the pointer
//   req        per-line request vector
//   grant      one-hot grant, combinational, zero when nothing requests
//   idx        encoded index of the granted line
//   valid      a grant is being issued this cycle
module dz_rr_arb
  import dz_pkg::*;
#(
  parameter  int NLINES = 8,
  localparam int LW     = clog2(NLINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NLINES-1:0] req,
  output logic [NLINES-1:0] grant,
  output logic [LW-1:0]     idx,
  output logic              valid
);

  logic [LW-1:0] ptr;
  logic [LW:0]   sum;
  logic [LW-1:0] j;

  // Walk the lines starting at ptr (wrapping) and take the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < NLINES; k++) begin
      sum = {1'b0, ptr} + (LW+1)'(k);
      j   = (sum >= (LW+1)'(NLINES)) ? LW'(sum - (LW+1)'(NLINES)) : LW'(sum);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (idx == LW'(NLINES - 1)) ? '0 : idx + LW'(1);
    end
  end

endmodule

// File: rtl/dz_rx_silo.sv
// rtl/dz_rx_silo.sv - DZ receive silo: scans the line receivers and presents the RBUF word
//   clk, rst         clock, asynchronous active-low reset
//   clr              synchronous clear (CSR CLR)
//   csrMSE, csrSAE   master scan enable, silo alarm enable
//   lineRXEN         per-line receiver enable
//   uartRXFULL/FRME/PARE/DATA  per-line receiver status and character
//   uartRXCLR        one-hot clear to the receiver serviced this cycle
//   rbufREAD         RBUF bus read strobe; the silo pops when it drops
//   rbufRDONE        silo not empty
//   rbufSA           silo alarm
//   siloLEVEL        entries currently stored
//   regRBUF          {DVAL, OVRE, FE, PE, 0, LINE, DATA}
module dz_rx_silo
  import dz_pkg::*;
#(
  parameter  int NLINES = 8,
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 64,
  parameter  int ALARM  = 16,
  localparam int LW     = clog2(NLINES),
  localparam int RW     = DWIDTH + LW + 5,
  localparam int LVW    = clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          csrMSE,
  input  logic                          csrSAE,
  input  logic [NLINES-1:0]             lineRXEN,
  input  logic [NLINES-1:0]             uartRXFULL,
  input  logic [NLINES-1:0]             uartRXFRME,
  input  logic [NLINES-1:0]             uartRXPARE,
  input  logic [NLINES-1:0][DWIDTH-1:0] uartRXDATA,
  output logic [NLINES-1:0]             uartRXCLR,
  input  logic                          rbufREAD,
  output logic                          rbufRDONE,
  output logic                          rbufSA,
  output logic [LVW-1:0]                siloLEVEL,
  output logic [RW-1:0]                 regRBUF
);

  localparam int EW = RW - 1;
  localparam int AC = clog2(ALARM + 1);

  typedef struct packed {
    dz_flags_t         flags;
    logic [LW-1:0]     line;
    logic [DWIDTH-1:0] data;
  } silo_ent_t;

  logic [NLINES-1:0] req;
  logic              gnt_valid;
  logic [LW-1:0]     gnt_idx;
  logic              store;
  logic              pop;
  logic              empty;
  logic              full;
  silo_ent_t         wr_ent;
  logic [EW-1:0]     head;
  logic [EW-1:0]     head_q;
  logic              dval_q;
  logic              read_q;
  logic              ovr_pend;
  logic [AC-1:0]     acnt;
  logic              sa_q;

  // Lines are not serviced during clr so no character is cleared from a receiver and then lost.
  assign req = uartRXFULL & lineRXEN & {NLINES{csrMSE & ~clr}};

  dz_rr_arb #(.NLINES(NLINES)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .req   (req),
    .grant (uartRXCLR),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  // A full silo drops the character even when a pop is due this same edge.
  assign store = gnt_valid & ~full;
  assign pop   = read_q & ~rbufREAD & ~empty;

  always_comb begin
    wr_ent            = '0;
    wr_ent.flags.ovre = ovr_pend;
    wr_ent.flags.fe   = uartRXFRME[gnt_idx];
    wr_ent.flags.pe   = uartRXPARE[gnt_idx];
    wr_ent.flags.rsv  = 1'b0;
    wr_ent.line       = gnt_idx;
    wr_ent.data       = uartRXDATA[gnt_idx];
  end

  dz_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_silo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (store),
    .wr_data (wr_ent),
    .rd_en   (pop),
    .rd_data (head),
    .level   (siloLEVEL),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_q   <= 1'b0;
      ovr_pend <= 1'b0;
      dval_q   <= 1'b0;
      head_q   <= '0;
      acnt     <= '0;
      sa_q     <= 1'b0;
    end else if (clr) begin
      read_q   <= 1'b0;
      ovr_pend <= 1'b0;
      dval_q   <= 1'b0;
      head_q   <= '0;
      acnt     <= '0;
      sa_q     <= 1'b0;
    end else begin
      read_q <= rbufREAD;
      // Any grant either stores (clearing the pending overrun) or is dropped on a full silo.
      if (gnt_valid) begin
        ovr_pend <= full;
      end
      // The head only changes on a pop or a write into an empty silo, so sampling it
      // every cycle keeps RBUF stable for the whole bus read; stale fields hold when empty.
      dval_q <= ~empty;
      if (!empty) begin
        head_q <= head;
      end
      if (pop || !csrSAE) begin
        acnt <= '0;
        sa_q <= 1'b0;
      end else begin
        if (store && acnt != AC'(ALARM)) begin
          acnt <= acnt + AC'(1);
        end
        if (acnt == AC'(ALARM)) begin
          sa_q <= 1'b1;
        end
      end
    end
  end

  assign regRBUF   = {dval_q, head_q};
  assign rbufRDONE = ~empty;
  assign rbufSA    = sa_q;

endmodule

// File: tb/tb_dz_rx_silo.sv
// tb/tb_dz_rx_silo.sv - directed self-checking bench for dz_rx_silo (default and small configurations)
module tb_dz_rx_silo;
  import dz_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, mse, sae;

  // default instance: NLINES=8, DWIDTH=8, DEPTH=64, ALARM=16
  logic [7:0]      rxen, full, fe, pe, rxclr;
  logic [7:0][7:0] data;
  logic            rbuf_read, rdone, sa;
  logic [6:0]      lvl;
  logic [15:0]     rbuf;

  // small instance: NLINES=16, DWIDTH=7, DEPTH=4, ALARM=2
  logic [15:0]      s_rxen, s_full, s_fe, s_pe, s_rxclr;
  logic [15:0][6:0] s_data;
  logic             s_rbuf_read, s_rdone, s_sa;
  logic [2:0]       s_lvl;
  logic [15:0]      s_rbuf;

  int total = 0;
  int bad   = 0;

  dz_rx_silo u_dut (
    .clk(clk), .rst(rst), .clr(clr), .csrMSE(mse), .csrSAE(sae),
    .lineRXEN(rxen), .uartRXFULL(full), .uartRXFRME(fe), .uartRXPARE(pe),
    .uartRXDATA(data), .uartRXCLR(rxclr), .rbufREAD(rbuf_read),
    .rbufRDONE(rdone), .rbufSA(sa), .siloLEVEL(lvl), .regRBUF(rbuf)
  );

  dz_rx_silo #(.NLINES(16), .DWIDTH(7), .DEPTH(4), .ALARM(2)) u_small (
    .clk(clk), .rst(rst), .clr(clr), .csrMSE(mse), .csrSAE(sae),
    .lineRXEN(s_rxen), .uartRXFULL(s_full), .uartRXFRME(s_fe), .uartRXPARE(s_pe),
    .uartRXDATA(s_data), .uartRXCLR(s_rxclr), .rbufREAD(s_rbuf_read),
    .rbufRDONE(s_rdone), .rbufSA(s_sa), .siloLEVEL(s_lvl), .regRBUF(s_rbuf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock; receivers drop FULL once their clear was seen at the edge.
  task automatic tick();
    logic [7:0]  c;
    logic [15:0] sc;
    @(negedge clk);
    c  = rxclr;
    sc = s_rxclr;
    @(posedge clk);
    #1;
    full   = full & ~c;
    s_full = s_full & ~sc;
    #1;
  endtask

  task automatic put(input int l, input logic [7:0] d, input logic f, input logic p);
    data[l] = d;
    fe[l]   = f;
    pe[l]   = p;
    full[l] = 1'b1;
    tick();
    fe[l]   = 1'b0;
    pe[l]   = 1'b0;
  endtask

  task automatic s_put(input int l, input logic [6:0] d);
    s_data[l] = d;
    s_full[l] = 1'b1;
    tick();
  endtask

  // Bus read: RBUF sampled mid-cycle, pop on the strobe's fall, new head one cycle later.
  task automatic rd_word(input bit sm, output logic [15:0] v);
    if (sm) s_rbuf_read = 1'b1;
    else    rbuf_read   = 1'b1;
    tick();
    v = sm ? s_rbuf : rbuf;
    tick();
    s_rbuf_read = 1'b0;
    rbuf_read   = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    rst = 1'b0; clr = 1'b0; mse = 1'b1; sae = 1'b1;
    rxen = 8'hFF; full = '0; fe = '0; pe = '0; data = '0; rbuf_read = 1'b0;
    s_rxen = 16'hFFFF; s_full = '0; s_fe = '0; s_pe = '0; s_data = '0; s_rbuf_read = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // reset state
    chk("rst_lvl", 32'(lvl), 0);
    chk("rst_rdone", 32'(rdone), 0);
    chk("rst_rbuf", 32'(rbuf), 0);
    chk("rst_sa", 32'(sa), 0);
    chk("rst_rxclr", 32'(rxclr), 0);
    chk("rst_s_lvl", 32'(s_lvl), 0);

    // asynchronous reset with 5 entries and a write pending
    for (int k = 0; k < 5; k++) put(0, 8'(8'h10 + k), 1'b0, 1'b0);
    tick();
    chk("five_lvl", 32'(lvl), 5);
    chk("five_head", 32'(rbuf), 32'h8010);
    full[0] = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_lvl", 32'(lvl), 0);
    chk("arst_rdone", 32'(rdone), 0);
    chk("arst_rbuf", 32'(rbuf), 0);
    chk("arst_sa", 32'(sa), 0);
    full = '0;
    #1;
    rst = 1'b1;
    tick();

    // synchronous clear with 3 entries
    for (int k = 0; k < 3; k++) put(0, 8'(k), 1'b0, 1'b0);
    tick();
    chk("three_lvl", 32'(lvl), 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_lvl", 32'(lvl), 0);
    chk("clr_rdone", 32'(rdone), 0);
    chk("clr_rbuf", 32'(rbuf), 0);

    // round-robin over lines 1, 3, 6
    data[1] = 8'h41; data[3] = 8'h42; data[6] = 8'h43;
    full = 8'h4A;
    #1;
    chk("rr_clr0", 32'(rxclr), 32'h02);
    tick();
    chk("rr_clr1", 32'(rxclr), 32'h08);
    tick();
    chk("rr_clr2", 32'(rxclr), 32'h40);
    tick();
    chk("rr_clr3", 32'(rxclr), 32'h00);
    chk("rr_lvl", 32'(lvl), 3);
    rd_word(0, v); chk("rr_rd1", 32'(v), 32'h8141);
    rd_word(0, v); chk("rr_rd3", 32'(v), 32'h8342);
    rd_word(0, v); chk("rr_rd6", 32'(v), 32'h8643);
    chk("rr_stale", 32'(rbuf), 32'h0643);
    chk("rr_rdone", 32'(rdone), 0);

    // disabled line is neither cleared nor stored
    rxen[3] = 1'b0;
    full[3] = 1'b1;
    #1;
    chk("dis_clr", 32'(rxclr), 0);
    tick();
    tick();
    chk("dis_lvl", 32'(lvl), 0);
    chk("dis_full", 32'(full[3]), 1);
    full = '0;
    rxen = 8'hFF;

    // overrun
    for (int k = 0; k < 64; k++) put(0, 8'(k), 1'b0, 1'b0);
    chk("ovr_full_lvl", 32'(lvl), 64);
    data[2] = 8'h55;
    full[2] = 1'b1;
    #1;
    chk("ovr_drop_clr", 32'(rxclr), 32'h04);
    tick();
    chk("ovr_drop_lvl", 32'(lvl), 64);
    rd_word(0, v); chk("ovr_rd0", 32'(v), 32'h8000);
    chk("ovr_pop_lvl", 32'(lvl), 63);
    put(4, 8'h66, 1'b1, 1'b0);
    chk("ovr_refill_lvl", 32'(lvl), 64);
    rd_word(0, v); chk("ovr_rd1", 32'(v), 32'h8001);
    put(5, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 62; k++) rd_word(0, v);
    rd_word(0, v); chk("ovr_flag", 32'(v), 32'hE466);
    chk("ovr_bit", 32'(v[rb_ovre(16)]), 1);
    rd_word(0, v); chk("ovr_next", 32'(v), 32'h9577);
    chk("ovr_empty_lvl", 32'(lvl), 0);

    // silo alarm
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 15; k++) put(0, 8'(k), 1'b0, 1'b0);
    tick();
    chk("sa_15", 32'(sa), 0);
    put(0, 8'h0F, 1'b0, 1'b0);
    chk("sa_16_now", 32'(sa), 0);
    tick();
    chk("sa_16_next", 32'(sa), 1);
    rd_word(0, v);
    chk("sa_after_rd", 32'(sa), 0);
    chk("sa_rd_lvl", 32'(lvl), 15);
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 10; k++) put(0, 8'(k), 1'b0, 1'b0);
    sae = 1'b0;
    tick();
    sae = 1'b1;
    for (int k = 0; k < 6; k++) put(0, 8'(k), 1'b0, 1'b0);
    tick();
    chk("sae_cleared", 32'(sa), 0);
    for (int k = 0; k < 10; k++) put(0, 8'(k), 1'b0, 1'b0);
    tick();
    chk("sae_recount", 32'(sa), 1);

    // simultaneous pop and write at level 10
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 10; k++) put(0, 8'(k), 1'b0, 1'b0);
    rbuf_read = 1'b1;
    tick();
    tick();
    rbuf_read = 1'b0;
    data[1] = 8'h11;
    full[1] = 1'b1;
    tick();
    chk("sim_lvl", 32'(lvl), 10);
    chk("sim_dval", 32'(rbuf[rb_dval(16)]), 1);
    tick();
    chk("sim_lvl2", 32'(lvl), 10);

    // scan disabled: no grants, reads still pop
    mse = 1'b0;
    full[5] = 1'b1;
    #1;
    chk("mse_clr", 32'(rxclr), 0);
    rd_word(0, v);
    chk("mse_lvl", 32'(lvl), 9);
    mse = 1'b1;
    #1;
    chk("mse_on_clr", 32'(rxclr), 32'h20);
    tick();
    chk("mse_on_lvl", 32'(lvl), 10);

    // simultaneous pop and write on a full silo
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 64; k++) put(0, 8'(k), 1'b0, 1'b0);
    rbuf_read = 1'b1;
    tick();
    tick();
    rbuf_read = 1'b0;
    data[2] = 8'h22;
    full[2] = 1'b1;
    #1;
    chk("fsim_clr", 32'(rxclr), 32'h04);
    tick();
    chk("fsim_lvl", 32'(lvl), 63);
    put(3, 8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 63; k++) rd_word(0, v);
    rd_word(0, v); chk("fsim_ovre", 32'(v), 32'hC333);

    // small configuration
    clr = 1'b1; tick(); clr = 1'b0;
    chk("sm_lvl0", 32'(s_lvl), 0);
    chk("sm_rbuf0", 32'(s_rbuf), 0);
    s_put(15, 7'h5A);
    tick();
    chk("sm_sa1", 32'(s_sa), 0);
    chk("sm_head", 32'(s_rbuf), 32'h87DA);
    s_put(9, 7'h01);
    chk("sm_sa2_now", 32'(s_sa), 0);
    tick();
    chk("sm_sa2_next", 32'(s_sa), 1);
    s_put(0, 7'h02);
    s_put(1, 7'h03);
    chk("sm_full_lvl", 32'(s_lvl), 4);
    s_data[14] = 7'h7F;
    s_full[14] = 1'b1;
    #1;
    chk("sm_drop_clr", 32'(s_rxclr), 32'h4000);
    tick();
    chk("sm_drop_lvl", 32'(s_lvl), 4);
    rd_word(1, v); chk("sm_rd15", 32'(v), 32'h87DA);
    chk("sm_sa_rd", 32'(s_sa), 0);
    s_put(2, 7'h10);
    rd_word(1, v); chk("sm_rd9", 32'(v), 32'h8481);
    rd_word(1, v); chk("sm_rd0", 32'(v), 32'h8002);
    rd_word(1, v); chk("sm_rd1", 32'(v), 32'h8083);
    rd_word(1, v); chk("sm_rd2_ovre", 32'(v), 32'hC110);
    chk("sm_end_lvl", 32'(s_lvl), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
